// File: rtl/cpu_io_nibble_bridge.sv
// Bridges CPU operand/result words to a 4-bit fabric interface: operands are streamed out
// as nibble beats (A then B, LSB first) and result nibbles are assembled into a held word.
module cpu_io_nibble_bridge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  res_err_o,
  output logic                  ovf_o,
  output logic [3:0]            OPA_O,
  output logic [3:0]            OPB_O,
  input  logic [3:0]            RES0_I,
  input  logic [3:0]            RES1_I,
  input  logic [3:0]            RES2_I
);

  localparam int unsigned N     = DATA_WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } tx_state_e;

  tx_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]            opa_q, opa_d;
  logic [2:0]            opb_q, opb_d;
  logic                  ready_q, ready_d;
  logic                  credit_q, credit_d;

  logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_err_q, res_err_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] tx_word;
  logic [3:0]            tx_nib;
  logic [DATA_WIDTH-1:0] acc_new;
  logic                  rx_at_top;
  logic                  unused_bits;

  assign unused_bits = ^{RES1_I[3:2], RES2_I[3:1]};

  // TX: next state plus the registered fabric outputs for the beat shown next cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    opa_d   = 4'h0;
    opb_d   = 3'b000;
    ready_d = 1'b0;
    tx_word = '0;
    tx_nib  = 4'h0;

    unique case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          a_d     = op_a_i;
          b_d     = op_b_i;
          idx_d   = '0;
          state_d = SEND_A;
        end
      end
      SEND_A, SEND_B: begin
        if (!RES2_I[0]) begin
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d   = '0;
            state_d = (state_q == SEND_A) ? SEND_B : IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_word = (state_d == SEND_B) ? b_d : a_d;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_d == IDX_W'(i)) tx_nib = tx_word[i*4 +: 4];
    end

    if (state_d != IDLE) begin
      opa_d = tx_nib;
      opb_d = {(state_d == SEND_B), (idx_d == '0), 1'b1};
    end
    ready_d = (state_d == IDLE);
  end

  // RX: beats are only accepted while no result is held; the pop and a drop can share an edge
  always_comb begin
    rx_idx_d    = rx_idx_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    ovf_d       = ovf_q;
    acc_new     = acc_q;
    rx_at_top   = (rx_idx_q == IDX_W'(N - 1));

    for (int unsigned i = 0; i < N; i++) begin
      if (rx_idx_q == IDX_W'(i)) acc_new[i*4 +: 4] = RES0_I;
    end

    if (res_valid_q && res_ready_i) res_valid_d = 1'b0;

    if (RES1_I[0]) begin
      if (res_valid_q) begin
        ovf_d = 1'b1;
      end else if (RES1_I[1] || rx_at_top) begin
        res_data_d  = acc_new;
        res_valid_d = 1'b1;
        res_err_d   = (RES1_I[1] != rx_at_top);
        rx_idx_d    = '0;
        acc_d       = '0;
      end else begin
        acc_d    = acc_new;
        rx_idx_d = rx_idx_q + IDX_W'(1);
      end
    end

    credit_d = ~res_valid_d;
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opa_q       <= 4'h0;
      opb_q       <= 3'b000;
      ready_q     <= 1'b1;
      credit_q    <= 1'b1;
      rx_idx_q    <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      ready_q     <= ready_d;
      credit_q    <= credit_d;
      rx_idx_q    <= rx_idx_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign op_ready_o  = ready_q;
  assign OPA_O       = opa_q;
  assign OPB_O       = {credit_q, opb_q};
  assign res_data_o  = res_data_q;
  assign res_valid_o = res_valid_q;
  assign res_err_o   = res_err_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cpu_io_nibble_bridge.sv
// Scoreboard bench for cpu_io_nibble_bridge: directed stimulus pushes expected TX beats and
// result words into queues; a negedge monitor pops and compares what the bridge presents.
module tb_cpu_io_nibble_bridge;

  localparam int unsigned DW = 32;

  logic          UserCLK;
  logic          resetn;
  logic [DW-1:0] op_a_i, op_b_i;
  logic          op_valid_i;
  logic          op_ready_o;
  logic [DW-1:0] res_data_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          res_err_o;
  logic          ovf_o;
  logic [3:0]    OPA_O, OPB_O;
  logic [3:0]    RES0_I, RES1_I, RES2_I;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [5:0]  txq[$];  // {sel_b, first, nibble}
  logic [32:0] rxq[$];  // {err, data}

  cpu_io_nibble_bridge #(.DATA_WIDTH(DW)) dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .res_data_o  (res_data_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_err_o   (res_err_o),
    .ovf_o       (ovf_o),
    .OPA_O       (OPA_O),
    .OPB_O       (OPB_O),
    .RES0_I      (RES0_I),
    .RES1_I      (RES1_I),
    .RES2_I      (RES2_I)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a TX beat is consumed when shown without stall; a result when res_valid_o rises
  logic        prev_rv = 1'b0;
  logic [5:0]  exp_beat;
  logic [32:0] exp_res;
  always @(negedge UserCLK) begin
    if (OPB_O[0] && !RES2_I[0]) begin
      if (txq.size() == 0) begin
        total_cnt++;
        $display("FAIL tx_unexpected_beat: got beat 0x%0h, expected none", {OPB_O[2:1], OPA_O});
      end else begin
        exp_beat = txq.pop_front();
        check("tx_beat", 32'({OPB_O[2:1], OPA_O}), 32'(exp_beat));
      end
    end
    if (res_valid_o && !prev_rv) begin
      if (rxq.size() == 0) begin
        total_cnt++;
        $display("FAIL rx_unexpected_result: got 0x%0h, expected none", res_data_o);
      end else begin
        exp_res = rxq.pop_front();
        check("rx_data", res_data_o, exp_res[31:0]);
        check("rx_err", 32'(res_err_o), 32'(exp_res[32]));
      end
    end
    prev_rv = res_valid_o;
  end

  task automatic push_tx(input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = (i < 8) ? a : b;
      txq.push_back({(i >= 8), ((i % 8) == 0), w[(i%8)*4 +: 4]});
    end
  endtask

  task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge UserCLK); #1;
    op_a_i = a; op_b_i = b; op_valid_i = 1'b1;
    @(posedge UserCLK); #1;
    op_valid_i = 1'b0;
  endtask

  task automatic rx_beat(input logic [3:0] nib, input logic last);
    @(posedge UserCLK); #1;
    RES0_I = nib;
    RES1_I = {2'b00, last, 1'b1};
  endtask

  task automatic rx_idle();
    @(posedge UserCLK); #1;
    RES1_I = 4'h0;
    RES0_I = 4'h0;
  endtask

  task automatic pop_res();
    @(posedge UserCLK); #1;
    res_ready_i = 1'b1;
    @(posedge UserCLK); #1;
    res_ready_i = 1'b0;
  endtask

  int cyc;
  int held6;
  int beats;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    resetn = 1'b0;
    op_a_i = '0; op_b_i = '0; op_valid_i = 1'b0;
    res_ready_i = 1'b0;
    RES0_I = 4'h0; RES1_I = 4'h0; RES2_I = 4'h0;

    // reset values
    @(negedge UserCLK);
    check("rst_opb", 32'(OPB_O), 32'h8);
    check("rst_opa", 32'(OPA_O), 32'h0);
    check("rst_ready", 32'(op_ready_o), 32'h1);
    check("rst_res_valid", 32'(res_valid_o), 32'h0);
    check("rst_res_data", res_data_o, 32'h0);
    check("rst_res_err", 32'(res_err_o), 32'h0);
    check("rst_ovf", 32'(ovf_o), 32'h0);
    resetn = 1'b1;

    // TX no stall
    push_tx(32'h12345678, 32'h9ABCDEF0, 16);
    send_op(32'h12345678, 32'h9ABCDEF0);
    cyc = 0;
    do begin @(negedge UserCLK); cyc++; end while (!op_ready_o && cyc < 200);
    check("tx_ready_cycle", 32'(cyc), 32'd17);
    check("tx_idle_opb", 32'(OPB_O), 32'h8);
    check("tx_idle_opa", 32'(OPA_O), 32'h0);

    // TX with a 3-cycle stall on beat 2
    push_tx(32'h12345678, 32'h9ABCDEF0, 16);
    send_op(32'h12345678, 32'h9ABCDEF0);
    fork
      begin
        cyc = 0; held6 = 0;
        do begin
          @(negedge UserCLK); cyc++;
          if (OPB_O[0] && OPA_O == 4'h6) held6++;
        end while (!op_ready_o && cyc < 200);
      end
      begin
        @(posedge UserCLK); @(posedge UserCLK); #1;
        RES2_I = 4'h1;
        repeat (3) @(posedge UserCLK);
        #1 RES2_I = 4'h0;
      end
    join
    check("stall_ready_cycle", 32'(cyc), 32'd20);
    check("stall_hold_cycles", 32'(held6), 32'd4);

    // RX full word
    rxq.push_back({1'b0, 32'h87654321});
    for (int i = 1; i <= 8; i++) rx_beat(4'(i), (i == 8));
    rx_idle();
    @(negedge UserCLK);
    check("rx_credit_low", 32'(OPB_O[3]), 32'h0);
    repeat (3) @(negedge UserCLK);
    check("rx_credit_held", 32'(OPB_O[3]), 32'h0);
    check("rx_data_held", res_data_o, 32'h87654321);
    pop_res();
    @(negedge UserCLK);
    check("rx_pop_valid", 32'(res_valid_o), 32'h0);
    check("rx_pop_credit", 32'(OPB_O[3]), 32'h1);

    // RX early last
    rxq.push_back({1'b1, 32'h00000CBA});
    rx_beat(4'hA, 1'b0);
    rx_beat(4'hB, 1'b0);
    rx_beat(4'hC, 1'b1);
    rx_idle();
    pop_res();
    @(negedge UserCLK);
    check("ovf_clear", 32'(ovf_o), 32'h0);

    // overflow: held result, one more beat is dropped
    rxq.push_back({1'b1, 32'h00000005});
    rx_beat(4'h5, 1'b1);
    rx_idle();
    rx_beat(4'h7, 1'b0);
    rx_idle();
    @(negedge UserCLK);
    check("ovf_set", 32'(ovf_o), 32'h1);
    check("ovf_data", res_data_o, 32'h5);
    check("ovf_valid", 32'(res_valid_o), 32'h1);
    pop_res();
    @(negedge UserCLK);
    check("ovf_sticky", 32'(ovf_o), 32'h1);
    rxq.push_back({1'b1, 32'h00000009});
    rx_beat(4'h9, 1'b1);
    rx_idle();
    pop_res();

    // reset mid-SEND_A at beat 3
    push_tx(32'h12345678, 32'h9ABCDEF0, 4);
    send_op(32'h12345678, 32'h9ABCDEF0);
    repeat (4) @(negedge UserCLK);
    check("mid_beat3", 32'(OPA_O), 32'h5);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_opb", 32'(OPB_O), 32'h8);
    check("mid_rst_opa", 32'(OPA_O), 32'h0);
    check("mid_rst_ready", 32'(op_ready_o), 32'h1);
    @(posedge UserCLK);
    @(negedge UserCLK);
    resetn = 1'b1;
    beats = 0;
    repeat (20) begin
      @(negedge UserCLK);
      if (OPB_O[0]) beats++;
    end
    check("mid_no_beats", 32'(beats), 32'h0);
    check("mid_ready", 32'(op_ready_o), 32'h1);
    check("mid_no_result", 32'(res_valid_o), 32'h0);

    check("txq_empty", 32'(txq.size()), 32'h0);
    check("rxq_empty", 32'(rxq.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_io_nibble_bridge.md
CPU_IO_NIBBLE_BRIDGE -- requirements
Module: cpu_io_nibble_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width; a multiple of 4; N = DATA_WIDTH/4 nibbles.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port UserCLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port op_a_i  in  DATA_WIDTH  CPU operand A.
REQ-006 SHALL have port op_b_i  in  DATA_WIDTH  CPU operand B.
REQ-007 SHALL have port op_valid_i  in  1  operand pair valid.
REQ-008 SHALL have port op_ready_o  out  1  bridge accepts an operand pair.
REQ-009 SHALL have port res_data_o  out  DATA_WIDTH  assembled result word.
REQ-010 SHALL have port res_valid_o  out  1  result word held.
REQ-011 SHALL have port res_ready_i  in  1  CPU consumes the result.
REQ-012 SHALL have port res_err_o  out  1  framing error on the held result.
REQ-013 SHALL have port ovf_o  out  1  sticky flag for a result beat dropped due to no credit.
REQ-014 SHALL have port OPA_O  out  4  operand nibble to the fabric.
REQ-015 SHALL have port OPB_O  out  4  control: [0] beat valid, [1] first beat, [2] 0=A/1=B, [3] result credit.
REQ-016 SHALL have port RES0_I  in  4  result nibble from the fabric.
REQ-017 SHALL have port RES1_I  in  4  [0] result beat valid, [1] last beat, [3:2] ignored.
REQ-018 SHALL have port RES2_I  in  4  [0] fabric stall for the operand stream, [3:1] ignored.

Function
REQ-019 SHALL drive OPA_O and OPB_O only from registered state; no combinational path from any input to any output.
REQ-020 SHALL run the TX FSM through states IDLE, SEND_A and SEND_B; op_ready_o = 1 only in IDLE.
REQ-021 SHALL, in IDLE when op_valid_i=1, latch op_a_i and op_b_i, set the beat index to 0 and enter SEND_A.
REQ-022 SHALL, in SEND_A or SEND_B, drive OPB_O[0]=1, OPA_O = nibble[idx] (LSB nibble first), OPB_O[1]=(idx==0) and OPB_O[2]=(state==SEND_B).
REQ-023 SHALL commit a beat at a clock edge only if RES2_I[0]=0, which advances idx; if RES2_I[0]=1, idx and OPA_O hold and OPB_O[0] stays 1.
REQ-024 SHALL, on committing idx N-1, go from SEND_A to SEND_B with idx 0, and from SEND_B to IDLE.
REQ-025 SHALL, with no stall and acceptance at edge k, present beats in cycles k+1..k+2N, with op_ready_o=1 again from cycle k+2N+1.
REQ-026 SHALL drive OPB_O[0]=0, OPB_O[1]=0, OPB_O[2]=0 and OPA_O=0 in IDLE.
REQ-027 SHALL drive OPB_O[3] = NOT res_valid_o in all states.
REQ-028 SHALL keep an RX index rx_idx (0..N-1) and an accumulator.
REQ-029 SHALL, on an edge with RES1_I[0]=1 and res_valid_o=0, write RES0_I into accumulator nibble rx_idx.
REQ-030 SHALL complete an RX beat when RES1_I[1]=1 or rx_idx==N-1: load res_data_o with the accumulator including this nibble (nibbles above rx_idx = 0), set res_valid_o=1, set res_err_o = (RES1_I[1] != (rx_idx==N-1)), and clear rx_idx and the accumulator.
REQ-031 SHALL otherwise increment rx_idx after each accepted RX beat.
REQ-032 SHALL, on an edge with RES1_I[0]=1 and res_valid_o=1, drop the beat, leave rx_idx unchanged and set ovf_o=1; ovf_o is cleared only by reset.
REQ-033 SHALL clear res_valid_o on an edge with res_valid_o=1 and res_ready_i=1; beats arriving at that same edge are still dropped (REQ-032).
REQ-034 SHALL run the TX and RX paths independently and concurrently.

Reset
REQ-035 SHALL, while resetn=0, immediately force: state IDLE, idx=0, rx_idx=0, accumulator=0, op_ready_o=1, OPA_O=0, OPB_O=4'b1000, res_data_o=0, res_valid_o=0, res_err_o=0, ovf_o=0.
REQ-036 SHALL abandon any in-progress TX or RX transaction when reset is asserted mid-operation, with no partial result delivered.

Verification
REQ-037 SHALL cover TX: A=0x12345678, B=0x9ABCDEF0, no stall -> OPA_O = 8,7,6,5,4,3,2,1 then 0,F,E,D,C,B,A,9; OPB_O[1]=1 on beats 0 and 8; op_ready_o=1 at cycle k+17.
REQ-038 SHALL cover TX stall: same operands, RES2_I[0]=1 for 3 cycles while beat 2 is shown -> nibble 6 held 4 cycles; last beat in cycle k+19.
REQ-039 SHALL cover RX: nibbles 1..8 with last on the 8th -> res_data_o=0x87654321, res_err_o=0, OPB_O[3]=0 until popped.
REQ-040 SHALL cover RX early last: nibbles A,B,C with last on the 3rd -> res_data_o=0x00000CBA, res_err_o=1.
REQ-041 SHALL cover overflow: result held with res_ready_i=0, then one more beat -> beat dropped, ovf_o=1, res_data_o unchanged.
REQ-042 SHALL cover reset mid-SEND_A at beat 3 -> OPB_O=4'b1000 asynchronously; after release, op_ready_o=1 and no beats are emitted.
